// File: rtl/spi_burst_if.sv
// SPI burst decoder bus bundle.
// Serial lines, register-file read data and decoded outputs.
interface spi_burst_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
);
  logic              pico;
  logic [WORD_W-1:0] rdata;
  logic              poci;
  logic              is_write;
  logic              incr_en;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              wr_strobe;
  logic              hdr_valid;
  logic [CNT_W-1:0]  word_cnt;
  logic              addr_wrap;

  modport slave (
    input  pico, rdata,
    output poci, is_write, incr_en, addr, wdata,
    output wr_strobe, hdr_valid, word_cnt, addr_wrap
  );

  modport master (
    output pico, rdata,
    input  poci, is_write, incr_en, addr, wdata,
    input  wr_strobe, hdr_valid, word_cnt, addr_wrap
  );
endinterface

// File: rtl/spi_burst_decoder.sv
// SPI mode-0 burst decoder: header, then write or read words.
// Writes strobe per word; reads stream rdata out gaplessly.
module spi_burst_decoder #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic        spi_clk,
  input  logic        full_rstn,
  spi_burst_if.slave  bus
);
  localparam int HDR_W = ADDR_W + 2;
  localparam int MAXW  = (HDR_W > WORD_W) ? HDR_W : WORD_W;
  localparam int CW    = $clog2(MAXW);

  typedef enum logic {HDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MAXW-2:0]   sh_q;
  logic              is_write_q;
  logic              incr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              hv_q;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              wrap_q;
  logic              stb_req_q;
  logic              stb_neg_q;
  logic [WORD_W-1:0] os_q;

  logic [MAXW-1:0]   shin;
  logic              hdr_done;
  logic              word_done;
  logic              addr_inc;
  logic [ADDR_W:0]   addr_sum;

  assign shin      = {sh_q, bus.pico};
  assign hdr_done  = (state_q == HDR) &&
                     (cnt_q == CW'(HDR_W - 1));
  assign word_done = (state_q == DATA) &&
                     (cnt_q == CW'(WORD_W - 1));
  assign addr_sum  = {1'b0, addr_q} + (ADDR_W + 1)'(1);

  // Next state, field bit counter and increment decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    wcnt_d   = (&wcnt_q) ? wcnt_q : wcnt_q + CNT_W'(1);
    addr_inc = 1'b0;
    if (hdr_done) begin
      state_d = DATA;
      cnt_d   = '0;
    end else if (word_done) begin
      cnt_d = '0;
    end
    if (incr_q) begin
      addr_inc = (word_done && !is_write_q) || stb_req_q;
    end
  end

  // Rising edge: sample pico, decode fields, advance address
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      state_q    <= HDR;
      cnt_q      <= '0;
      sh_q       <= '0;
      is_write_q <= 1'b0;
      incr_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hv_q       <= 1'b0;
      wcnt_q     <= '0;
      wrap_q     <= 1'b0;
      stb_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= shin[MAXW-2:0];
      stb_req_q <= word_done && is_write_q;
      if (hdr_done) begin
        is_write_q <= shin[HDR_W-1];
        incr_q     <= shin[HDR_W-2];
        addr_q     <= shin[ADDR_W-1:0];
        hv_q       <= 1'b1;
      end
      if (word_done) begin
        wcnt_q <= wcnt_d;
        if (is_write_q) begin
          wdata_q <= shin[WORD_W-1:0];
        end
      end
      if (addr_inc) begin
        addr_q <= addr_sum[ADDR_W-1:0];
        if (addr_sum[ADDR_W]) begin
          wrap_q <= 1'b1;
        end
      end
    end
  end

  // Falling edge: launch strobe, load/shift read data
  always_ff @(negedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      stb_neg_q <= 1'b0;
      os_q      <= '0;
    end else begin
      stb_neg_q <= stb_req_q;
      if (state_q == DATA && !is_write_q && cnt_q == '0) begin
        os_q <= bus.rdata;
      end else begin
        os_q <= {os_q[WORD_W-2:0], 1'b0};
      end
    end
  end

  assign bus.poci      = os_q[WORD_W-1];
  assign bus.is_write  = is_write_q;
  assign bus.incr_en   = incr_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wr_strobe = stb_neg_q & stb_req_q;
  assign bus.hdr_valid = hv_q;
  assign bus.word_cnt  = wcnt_q;
  assign bus.addr_wrap = wrap_q;
endmodule

// File: tb/tb_spi_burst_decoder.sv
// Scoreboard bench for spi_burst_decoder.
// Directed plan cases, then random bursts and aborts.
module tb_spi_burst_decoder;
  localparam int AW = 6;
  localparam int WW = 8;
  localparam int CW = 8;

  logic spi_clk = 1'b0;
  logic full_rstn = 1'b1;

  spi_burst_if #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW)) bus ();

  spi_burst_decoder #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW)) dut (
    .spi_clk   (spi_clk),
    .full_rstn (full_rstn),
    .bus       (bus)
  );

  always #5 spi_clk = ~spi_clk;

  assign bus.rdata = {2'b00, bus.addr} ^ 8'h55;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } stb_t;

  stb_t sq[$];
  bit   pq[$];
  logic [7:0] wd [0:7];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // poci monitor: just before each rising edge
  initial begin
    bit b;
    forever begin
      @(negedge spi_clk);
      #4;
      if (full_rstn && bus.hdr_valid && !bus.is_write) begin
        if (pq.size() > 0) begin
          b = pq.pop_front();
          chk("poci", bus.poci, b);
        end
      end else if (full_rstn && bus.hdr_valid) begin
        chk("poci_write", bus.poci, 0);
      end
    end
  end

  // strobe monitor
  initial begin
    stb_t e;
    forever begin
      @(posedge bus.wr_strobe);
      #1;
      if (sq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe_unexpected: addr=%0h wdata=%0h expected none",
                 bus.addr, bus.wdata);
      end else begin
        e = sq.pop_front();
        chk("stb_addr", bus.addr, e.a);
        chk("stb_wdata", bus.wdata, e.d);
      end
    end
  end

  task automatic run(input logic [7:0] hdr, input int hbits,
                     input int dbits);
    bit iw;
    bit inc;
    int base, n, incs, w, wa, d;
    stb_t e;
    iw   = hdr[7];
    inc  = hdr[6];
    base = int'(hdr[5:0]);
    n    = dbits / 8;
    incs = 0;
    if (hbits == 8) begin
      if (iw) begin
        for (int k = 0; k < n; k++) begin
          e.a = 6'((base + (inc ? k : 0)) % 64);
          e.d = wd[k];
          sq.push_back(e);
        end
        if (inc)
          for (int k = 1; k <= n; k++)
            if (8 * k + 1 <= dbits) incs++;
      end else begin
        for (int i = 0; i < dbits; i++) begin
          w  = i / 8;
          wa = (base + (inc ? w : 0)) % 64;
          pq.push_back(((wa ^ 'h55) >> (7 - i % 8)) & 1);
        end
        if (inc) incs = n;
      end
    end
    for (int i = 0; i < hbits + dbits; i++) begin
      @(negedge spi_clk);
      if (i == 0) full_rstn = 1'b1;
      if (i < hbits) begin
        bus.pico = hdr[7 - i];
      end else begin
        d = i - hbits;
        bus.pico = wd[d / 8][7 - d % 8];
      end
    end
    @(negedge spi_clk);
    #1;
    if (hbits == 8) begin
      chk("hdr_valid", bus.hdr_valid, 1);
      chk("is_write", bus.is_write, iw);
      chk("incr_en", bus.incr_en, inc);
      chk("final_addr", bus.addr, (base + incs) % 64);
      chk("word_cnt", bus.word_cnt, n > 255 ? 255 : n);
      chk("addr_wrap", bus.addr_wrap, inc && (base + incs >= 64));
    end else begin
      chk("hdr_valid_part", bus.hdr_valid, 0);
      chk("word_cnt_part", bus.word_cnt, 0);
    end
    #1 full_rstn = 1'b0;
    #1;
    chk("reset_outputs",
        {bus.poci, bus.is_write, bus.incr_en, bus.addr, bus.wdata,
         bus.wr_strobe, bus.hdr_valid, bus.word_cnt, bus.addr_wrap}, 0);
    repeat (2) @(negedge spi_clk);
    chk("stb_pending", sq.size(), 0);
    chk("poci_pending", pq.size(), 0);
    sq.delete();
    pq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, part, extra, hb;
    bus.pico = 1'b0;
    #1 full_rstn = 1'b0;
    #20;
    chk("reset_state",
        {bus.poci, bus.is_write, bus.incr_en, bus.addr, bus.wdata,
         bus.wr_strobe, bus.hdr_valid, bus.word_cnt, bus.addr_wrap}, 0);

    wd[0] = 8'hA5; wd[1] = 8'h3C;
    run(8'hC5, 8, 17);
    run(8'h4A, 8, 16);
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    run(8'h85, 8, 24);
    wd[0] = 8'h01; wd[1] = 8'h02;
    run(8'hFF, 8, 17);
    run(8'hC5, 8, 5);
    run(8'h45, 8, 0);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) wd[k] = 8'($urandom);
      nw    = $urandom_range(0, 4);
      part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      extra = $urandom_range(0, 1);
      hb    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
      if (hb < 8)
        run(8'($urandom), hb, 0);
      else
        run(8'($urandom), 8, nw * 8 + (part > 0 ? part : extra));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
